// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerator datapath constants and tile fetch state type
package accel_pkg;

  localparam int DATA_W  = 16;
  localparam int SRAM_AW = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } tile_fetch_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - tile walker: row/column counters and SRAM address, wrapping mod 2^ADDR_WID
module tile_addr_gen
  import accel_pkg::*;
#(
  parameter int ADDR_WID = SRAM_AW,
  parameter int CNT_WID  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                advance,
  input  logic [ADDR_WID-1:0] base_addr,
  input  logic [ADDR_WID-1:0] row_stride,
  input  logic [CNT_WID-1:0]  num_rows,
  input  logic [CNT_WID-1:0]  num_cols,
  output logic [ADDR_WID-1:0] raddr,
  output logic                col_last,
  output logic                row_last
);

  logic [ADDR_WID-1:0] row_base_q, row_base_d;
  logic [ADDR_WID-1:0] stride_q, stride_d;
  logic [CNT_WID-1:0]  row_q, row_d;
  logic [CNT_WID-1:0]  col_q, col_d;
  logic [CNT_WID-1:0]  rows_q, rows_d;
  logic [CNT_WID-1:0]  cols_q, cols_d;

  assign raddr    = row_base_q + ADDR_WID'(col_q);
  assign col_last = (col_q == cols_q - CNT_WID'(1));
  assign row_last = (row_q == rows_q - CNT_WID'(1));

  always_comb begin
    row_base_d = row_base_q;
    stride_d   = stride_q;
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    if (load) begin
      // Shape is latched here so input changes mid-tile cannot disturb the walk.
      row_base_d = base_addr;
      stride_d   = row_stride;
      rows_d     = num_rows;
      cols_d     = num_cols;
      row_d      = '0;
      col_d      = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d      = '0;
        row_d      = row_q + CNT_WID'(1);
        row_base_d = row_base_q + stride_q;
      end else begin
        col_d = col_q + CNT_WID'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base_q <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
    end else begin
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
    end
  end

endmodule

// File: rtl/tile_fetch.sv
// rtl/tile_fetch.sv - streams a rows x cols tile from feature-map SRAM through a registered output stage
module tile_fetch
  import accel_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int ADDR_WID = SRAM_AW,
  parameter int CNT_WID  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WID-1:0] base_addr,
  input  logic [ADDR_WID-1:0] row_stride,
  input  logic [CNT_WID-1:0]  num_rows,
  input  logic [CNT_WID-1:0]  num_cols,
  output logic [ADDR_WID-1:0] raddr,
  input  logic [WIDTH-1:0]    rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_row_end,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  tile_fetch_state_t state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_row_end_q, out_row_end_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              load;
  logic              advance;
  logic              col_last;
  logic              row_last;

  tile_addr_gen #(
    .ADDR_WID(ADDR_WID),
    .CNT_WID (CNT_WID)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .base_addr (base_addr),
    .row_stride(row_stride),
    .num_rows  (num_rows),
    .num_cols  (num_cols),
    .raddr     (raddr),
    .col_last  (col_last),
    .row_last  (row_last)
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_row_end_d = out_row_end_q;
    out_last_d    = out_last_q;
    done_d        = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_rows != '0 && num_cols != '0) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A free or draining output slot takes the element the SRAM shows this cycle.
        if (!out_valid_q || out_ready) begin
          out_data_d    = rdata;
          out_valid_d   = 1'b1;
          out_row_end_d = col_last;
          out_last_d    = col_last && row_last;
          advance       = 1'b1;
          if (col_last && row_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (out_valid_q && out_ready) begin
          out_valid_d   = 1'b0;
          out_row_end_d = 1'b0;
          out_last_d    = 1'b0;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_row_end_q <= 1'b0;
      out_last_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_row_end_q <= out_row_end_d;
      out_last_q    <= out_last_d;
      done_q        <= done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row_end = out_row_end_q;
  assign out_last    = out_last_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tile_fetch.sv
// tb/tb_tile_fetch.sv - randomized scoreboard bench for tile_fetch against a tile-walk reference model
module tb_tile_fetch;

  localparam int W  = 16;
  localparam int AW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] row_stride;
  logic [CW-1:0] num_rows;
  logic [CW-1:0] num_cols;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_row_end;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [W-1:0] mem [0:4095];

  typedef struct packed {
    logic [W-1:0] data;
    logic         row_end;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_popped = 0;
  bit   zero_start_evt = 1'b0;
  int   ready_mode = 0;

  tile_fetch #(.WIDTH(W), .ADDR_WID(AW), .CNT_WID(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .raddr      (raddr),
    .rdata      (rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row_end(out_row_end),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  assign rdata = mem[raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference walk: element (r,c) lives at base + r*stride + c modulo the 4096-word space.
  task automatic push_tile(input int base, input int stride, input int rows, input int cols);
    exp_t e;
    int   a;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a         = (base + r * stride + c) % 4096;
        e.data    = mem[a];
        e.row_end = (c == cols - 1);
        e.last    = (r == rows - 1) && (c == cols - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    exp_t         e;
    bit           done_exp = 1'b0;
    bit           held_v = 1'b0;
    logic [W+1:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        done_exp       = 1'b0;
        held_v         = 1'b0;
        zero_start_evt = 1'b0;
      end else begin
        chk("done", 32'(done), 32'(done_exp));
        if (!out_valid) begin
          chk("row_end_idle", 32'(out_row_end), 32'd0);
          chk("last_idle", 32'(out_last), 32'd0);
        end
        if (held_v) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", 32'({out_data, out_row_end, out_last}), 32'(held));
        end
        done_exp = 1'b0;
        if (zero_start_evt) begin
          done_exp       = 1'b1;
          zero_start_evt = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_element actual=%0h expected=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("data", 32'(out_data), 32'(e.data));
            chk("row_end", 32'(out_row_end), 32'(e.row_end));
            chk("last", 32'(out_last), 32'(e.last));
            n_popped++;
            if (e.last) done_exp = 1'b1;
          end
        end
        held_v = out_valid && !out_ready;
        held   = {out_data, out_row_end, out_last};
      end
    end
  end

  task automatic run_tile(input int base, input int stride, input int rows, input int cols,
                          input bit disturb);
    int cyc = 0;
    bit seen = 1'b0;
    bit empty = (rows == 0) || (cols == 0);
    @(posedge clk);
    #1;
    base_addr  = AW'(base);
    row_stride = AW'(stride);
    num_rows   = CW'(rows);
    num_cols   = CW'(cols);
    start      = 1'b1;
    if (empty) zero_start_evt = 1'b1;
    else push_tile(base, stride, rows, cols);
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        start = 1'b0;
        if (!empty) chk("busy_run", 32'(busy), 32'd1);
      end
      if (disturb && cyc == 4) begin
        start      = 1'b1;
        base_addr  = AW'($urandom);
        row_stride = AW'($urandom);
        num_rows   = CW'($urandom_range(1, 9));
        num_cols   = CW'($urandom_range(1, 9));
      end
      if (disturb && cyc == 5) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout actual=none expected=done");
    end else begin
      chk("busy_idle", 32'(busy), 32'd0);
      if (ready_mode == 0)
        chk("latency", 32'(cyc), empty ? 32'd2 : 32'(rows * cols + 3));
    end
  endtask

  task automatic reset_mid_tile();
    int p0 = n_popped;
    int cyc = 0;
    ready_mode = 0;
    @(posedge clk);
    #1;
    base_addr  = AW'(12'h3C0);
    row_stride = AW'(32);
    num_rows   = CW'(4);
    num_cols   = CW'(4);
    start      = 1'b1;
    push_tile(12'h3C0, 32, 4, 4);
    while (n_popped < p0 + 2 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 2) start = 1'b0;
    end
    chk("reset_reach_elem2", 32'(n_popped - p0), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_row_end", 32'(out_row_end), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_tile(12'h3C0, 32, 4, 4, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {4'($urandom_range(0, 15)), 12'(i)};
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    row_stride = '0;
    num_rows   = '0;
    num_cols   = '0;
    out_ready  = 1'b1;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_raddr", 32'(raddr), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    ready_mode = 0;
    run_tile(12'h010, 8, 2, 3, 1'b0);
    ready_mode = 1;
    run_tile(12'h010, 8, 2, 3, 1'b0);
    ready_mode = 0;
    run_tile(12'hFFE, 4, 2, 2, 1'b0);
    run_tile(12'h100, 3, 0, 5, 1'b0);
    run_tile(12'h200, 3, 4, 0, 1'b0);
    reset_mid_tile();
    ready_mode = 0;
    run_tile(100, 20, 3, 4, 1'b1);
    ready_mode = 2;
    run_tile(12'hF80, 12'h7F0, 3, 5, 1'b1);
    for (int t = 0; t < 12; t++) begin
      ready_mode = $urandom_range(0, 2);
      run_tile(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
               int'($urandom_range(0, 5)), int'($urandom_range(1, 6)), 1'b0);
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
